// File: rtl/usb_tx_encoder_pkg.sv
// Shared types for the USB TX line encoder: encoder states, line levels and NRZI toggle helper.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        EOP_SE0 = 2'd2,
        EOP_J   = 2'd3
    } state_t;

    typedef struct packed {
        logic dp;
        logic dm;
    } line_t;

    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

    // NRZI transmits a 0 as a J<->K transition; only meaningful while the line is J or K.
    function automatic line_t nrzi_toggle(input line_t l);
        return (l == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_encoder_if.sv
// Bit-level handshake between TX control and the line encoder.
// Optional USB_TX_OE_EN adds the d_oe output-enable signal.
interface usb_tx_encoder_if;
    logic bit_strobe;
    logic serial_in;
    logic tx_start;
    logic eop;
    logic stuffing;
    logic dplus;
    logic dminus;
    logic eop_done;
`ifdef USB_TX_OE_EN
    logic d_oe;
`endif

    modport master (
        output bit_strobe, serial_in, tx_start, eop,
        input  stuffing, dplus, dminus, eop_done
`ifdef USB_TX_OE_EN
        , input d_oe
`endif
    );

    modport slave (
        input  bit_strobe, serial_in, tx_start, eop,
        output stuffing, dplus, dminus, eop_done
`ifdef USB_TX_OE_EN
        , output d_oe
`endif
    );
endinterface

// File: rtl/usb_tx_encoder_bit_stuffer.sv
// Consecutive-ones counter; flags when the next bit boundary must carry a stuffed 0.
module usb_bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LIMIT = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_step,
    input  logic i_bit,
    input  logic i_clr,
    output logic o_stuff_now
);
    localparam int CNT_W = $clog2(STUFF_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUFF_LIMIT);

    logic [CNT_W-1:0] r_ones_cnt;

    assign o_stuff_now = i_active && (r_ones_cnt == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones_cnt <= '0;
        end else if (i_clr) begin
            r_ones_cnt <= '0;
        end else if (i_step) begin
            r_ones_cnt <= i_bit ? r_ones_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/usb_tx_encoder.sv
// USB TX line stage: bit stuffing, NRZI encoding and EOP (SE0,SE0,J) generation onto D+/D-.
// Define USB_TX_OE_EN to add the registered d_oe output enable.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LIMIT  = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic           clk,
    input  logic           rst,
    usb_tx_encoder_if.slave bus
);
    localparam int SE0_W = $clog2(EOP_SE0_BITS + 1);
    localparam logic [SE0_W-1:0] SE0_LAST = SE0_W'(EOP_SE0_BITS - 1);

    state_t           r_state,       w_state_nxt;
    line_t            r_line,        w_line_nxt;
    logic             r_armed,       w_armed_nxt;
    logic             r_eop_pending, w_eop_pending_nxt;
    logic             r_eop_done,    w_eop_done_nxt;
    logic [SE0_W-1:0] r_se0_cnt,     w_se0_cnt_nxt;
    logic             r_oe,          w_oe_nxt;
    logic             w_stuff_now;
    logic             w_step;
    logic             w_clr;
    logic             w_start;

    usb_bit_stuffer #(.STUFF_LIMIT(STUFF_LIMIT)) u_stuffer (
        .clk         (clk),
        .rst         (rst),
        .i_active    (r_state == DATA),
        .i_step      (w_step),
        .i_bit       (bus.serial_in),
        .i_clr       (w_clr),
        .o_stuff_now (w_stuff_now)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_line_nxt        = r_line;
        w_armed_nxt       = r_armed;
        w_eop_pending_nxt = r_eop_pending;
        w_eop_done_nxt    = 1'b0;
        w_se0_cnt_nxt     = r_se0_cnt;
        w_oe_nxt          = r_oe;
        w_step            = 1'b0;
        w_clr             = 1'b0;
        // A strobe landing in the same cycle as tx_start already starts the packet.
        w_start           = r_armed | bus.tx_start;

        case (r_state)
            IDLE: begin
                w_line_nxt = LINE_J;
                if (bus.tx_start)
                    w_armed_nxt = 1'b1;
                if (bus.bit_strobe && w_start) begin
                    w_state_nxt = DATA;
                    w_armed_nxt = 1'b0;
                    w_step      = 1'b1;
                    w_oe_nxt    = 1'b1;
                    w_line_nxt  = bus.serial_in ? LINE_J : LINE_K;
                end
            end
            DATA: begin
                if (bus.eop)
                    w_eop_pending_nxt = 1'b1;
                if (bus.bit_strobe) begin
                    // An owed stuff bit wins over EOP so the receiver never sees seven 1s.
                    if (w_stuff_now) begin
                        w_line_nxt = nrzi_toggle(r_line);
                        w_clr      = 1'b1;
                    end else if (r_eop_pending) begin
                        w_state_nxt       = EOP_SE0;
                        w_line_nxt        = LINE_SE0;
                        w_eop_pending_nxt = 1'b0;
                        w_se0_cnt_nxt     = '0;
                        w_clr             = 1'b1;
                    end else begin
                        w_step = 1'b1;
                        if (!bus.serial_in)
                            w_line_nxt = nrzi_toggle(r_line);
                    end
                end
            end
            EOP_SE0: begin
                if (bus.bit_strobe) begin
                    if (r_se0_cnt == SE0_LAST) begin
                        w_state_nxt = EOP_J;
                        w_line_nxt  = LINE_J;
                    end else begin
                        w_se0_cnt_nxt = r_se0_cnt + 1'b1;
                    end
                end
            end
            EOP_J: begin
                if (bus.bit_strobe) begin
                    w_state_nxt    = IDLE;
                    w_eop_done_nxt = 1'b1;
                    w_oe_nxt       = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_line_nxt  = LINE_J;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_line        <= LINE_J;
            r_armed       <= 1'b0;
            r_eop_pending <= 1'b0;
            r_eop_done    <= 1'b0;
            r_se0_cnt     <= '0;
            r_oe          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_line        <= w_line_nxt;
            r_armed       <= w_armed_nxt;
            r_eop_pending <= w_eop_pending_nxt;
            r_eop_done    <= w_eop_done_nxt;
            r_se0_cnt     <= w_se0_cnt_nxt;
            r_oe          <= w_oe_nxt;
        end
    end

    assign bus.stuffing = w_stuff_now;
    assign bus.dplus    = r_line.dp;
    assign bus.dminus   = r_line.dm;
    assign bus.eop_done = r_eop_done;
`ifdef USB_TX_OE_EN
    assign bus.d_oe     = r_oe;
`else
    logic w_oe_unused;
    assign w_oe_unused = r_oe;
`endif
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: sync/NRZI, stuffing, EOP, ignored controls and async reset.
module tb_usb_tx_encoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_tx_encoder_if bus();

    usb_tx_encoder #(.STUFF_LIMIT(6), .EOP_SE0_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic dp, input logic dm);
        check_eq({tag, ".dp"}, 32'(bus.dplus), 32'(dp));
        check_eq({tag, ".dm"}, 32'(bus.dminus), 32'(dm));
    endtask

    task automatic check_oe(input string tag, input logic exp);
`ifdef USB_TX_OE_EN
        check_eq({tag, ".oe"}, 32'(bus.d_oe), 32'(exp));
`else
        if (tag.len() < 0 && exp) $display("%s", tag);
`endif
    endtask

    task automatic strobe(input logic b);
        @(negedge clk);
        bus.serial_in  = b;
        bus.bit_strobe = 1'b1;
        @(negedge clk);
        bus.bit_strobe = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    task automatic pulse_eop();
        @(negedge clk);
        bus.eop = 1'b1;
        @(negedge clk);
        bus.eop = 1'b0;
    endtask

    // Sync byte LSB first: seven 0s then a 1; expected D+ after each bit is K J K J K J K K.
    logic [7:0] sync_bits = 8'b1000_0000;
    logic [7:0] sync_dp   = 8'b0010_1010;
    int stf3[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    int dp3[9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.bit_strobe = 1'b0;
        bus.serial_in  = 1'b0;
        bus.tx_start   = 1'b0;
        bus.eop        = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_line("reset", 1'b1, 1'b0);
        check_eq("reset.stuffing", 32'(bus.stuffing), 0);
        check_eq("reset.eop_done", 32'(bus.eop_done), 0);
        check_oe("reset", 1'b0);

        // Sync pattern
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            strobe(sync_bits[i]);
            check_line($sformatf("sync%0d", i), sync_dp[i], ~sync_dp[i]);
        end
        check_oe("sync", 1'b1);

        // Eight 1s with the sync's trailing 1 already counted: stuff after the fifth data 1
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("ones%0d.stuffing", i), 32'(bus.stuffing), 32'(stf3[i]));
            strobe(1'b1);
            check_line($sformatf("ones%0d", i), dp3[i][0], ~dp3[i][0]);
        end

        // EOP with no stuff owed
        pulse_eop();
        strobe(1'b0);
        check_line("eop.se0a", 1'b0, 1'b0);
        check_eq("eop.se0a.stuffing", 32'(bus.stuffing), 0);
        strobe(1'b0);
        check_line("eop.se0b", 1'b0, 1'b0);
        check_eq("eop.se0b.done", 32'(bus.eop_done), 0);
        check_oe("eop.se0b", 1'b1);
        strobe(1'b0);
        check_line("eop.j", 1'b1, 1'b0);
        check_eq("eop.j.done", 32'(bus.eop_done), 0);
        strobe(1'b0);
        check_line("eop.idle", 1'b1, 1'b0);
        check_eq("eop.idle.done", 32'(bus.eop_done), 1);
        check_oe("eop.idle", 1'b0);
        @(negedge clk);
        check_eq("eop.done_pulse", 32'(bus.eop_done), 0);

        // eop while IDLE is ignored
        pulse_eop();
        strobe(1'b0);
        check_line("idle_eop.a", 1'b1, 1'b0);
        check_eq("idle_eop.a.done", 32'(bus.eop_done), 0);
        strobe(1'b0);
        check_line("idle_eop.b", 1'b1, 1'b0);
        check_eq("idle_eop.b.done", 32'(bus.eop_done), 0);

        // tx_start coincident with the first strobe; tx_start in DATA ignored; stuff owed at EOP
        @(negedge clk);
        bus.tx_start   = 1'b1;
        bus.bit_strobe = 1'b1;
        bus.serial_in  = 1'b0;
        @(negedge clk);
        bus.tx_start   = 1'b0;
        bus.bit_strobe = 1'b0;
        check_line("co_start", 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            if (i == 4) pulse_start();
            strobe(sync_bits[i]);
            check_line($sformatf("sync2_%0d", i), sync_dp[i], ~sync_dp[i]);
        end
        strobe(1'b0);
        check_line("p2.zero", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("p2.one%0d.stuffing", i), 32'(bus.stuffing), 0);
            strobe(1'b1);
            check_line($sformatf("p2.one%0d", i), 1'b1, 1'b0);
        end
        check_eq("p2.owed.stuffing", 32'(bus.stuffing), 1);
        pulse_eop();
        check_eq("p2.eop.stuffing", 32'(bus.stuffing), 1);
        strobe(1'b0);
        check_line("p2.stuff", 1'b0, 1'b1);
        check_eq("p2.stuff.stuffing", 32'(bus.stuffing), 0);
        strobe(1'b0);
        check_line("p2.se0a", 1'b0, 1'b0);
        strobe(1'b0);
        check_line("p2.se0b", 1'b0, 1'b0);
        strobe(1'b0);
        check_line("p2.j", 1'b1, 1'b0);
        check_eq("p2.j.done", 32'(bus.eop_done), 0);
        strobe(1'b0);
        check_eq("p2.idle.done", 32'(bus.eop_done), 1);
        strobe(1'b0);
        check_line("p2.not_armed", 1'b1, 1'b0);
        check_eq("p2.not_armed.done", 32'(bus.eop_done), 0);

        // Asynchronous reset mid-packet with a stuff bit owed
        pulse_start();
        strobe(1'b0);
        check_line("rr.first", 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) strobe(1'b1);
        check_eq("rr.pre.stuffing", 32'(bus.stuffing), 1);
        #2 rst = 1'b1;
        #1;
        check_line("rr.async", 1'b1, 1'b0);
        check_eq("rr.async.stuffing", 32'(bus.stuffing), 0);
        check_eq("rr.async.done", 32'(bus.eop_done), 0);
        check_oe("rr.async", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        strobe(1'b0);
        check_line("rr.idle", 1'b1, 1'b0);
        check_eq("rr.idle.stuffing", 32'(bus.stuffing), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
